// File: rtl/rr_request_agent.sv
// rr_request_agent: requester-side companion of the static round-robin arbiter.
// Captures rising edges on the interrupt lines into pending bits and presents
// them to the arbiter. It turns the arbiter's answer into a one-hot service
// grant and watches each service for completion or timeout. Overrun, timeout
// and protocol problems are latched in sticky flags.
module rr_request_agent #(
    parameter int N_SRC       = 4,
    parameter int IDX_W       = 2,
    parameter int SVC_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] Irq_in,
    output logic [N_SRC-1:0] Priority_bus,
    input  logic [IDX_W-1:0] Next_priority,
    input  logic             Data_Valid,
    output logic [N_SRC-1:0] Svc_grant,
    input  logic             Svc_done,
    output logic [N_SRC-1:0] Overrun,
    output logic             Timeout_err,
    output logic             Proto_err,
    output logic [CNT_W-1:0] Grant_cnt,
    input  logic             Err_clr
);

    localparam int TMR_W = 8;
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(SVC_TIMEOUT - 1);
    localparam logic [IDX_W:0]   N_SRC_LIM = N_SRC[IDX_W:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N_SRC-1:0]   irq_q_r;
    logic [N_SRC-1:0]   pending_r;
    logic [N_SRC-1:0]   pending_nxt_s;
    logic [N_SRC-1:0]   grant_r;
    logic [N_SRC-1:0]   grant_nxt_s;
    logic [N_SRC-1:0]   ovr_r;
    logic [N_SRC-1:0]   ovr_nxt_s;
    logic               tout_r;
    logic               tout_nxt_s;
    logic               proto_r;
    logic               proto_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_nxt_s;
    logic [N_SRC-1:0]   edge_s;
    logic [N_SRC-1:0]   ovr_set_s;
    logic [N_SRC-1:0]   clear_s;
    logic               sel_pending_s;
    logic               tout_set_s;
    logic               proto_set_s;

    // One-hot decode of a source index; indices beyond N_SRC decode to zero.
    function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_SRC-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec[i] = (idx == i[IDX_W-1:0]);
        end
        return vec;
    endfunction

    // A new request is a rising edge. irq_q starts at zero, so a line already
    // high at reset release counts as an edge. An edge on a bit that is still
    // pending is an overrun.
    always_comb begin
        edge_s    = Irq_in & ~irq_q_r;
        ovr_set_s = edge_s & pending_r;
    end

    // Check whether the arbiter's chosen index names a pending source.
    // Out-of-range indices count as not pending.
    always_comb begin
        sel_pending_s = 1'b0;
        if ({1'b0, Next_priority} < N_SRC_LIM) begin
            sel_pending_s = pending_r[Next_priority];
        end else begin
            sel_pending_s = 1'b0;
        end
    end

    // Next-state and datapath decisions for the IDLE/SERVICE/RECOVER handshake.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        cnt_nxt_s   = cnt_r;
        timer_nxt_s = timer_r;
        clear_s     = '0;
        tout_set_s  = 1'b0;
        proto_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Data_Valid) begin
                    if (sel_pending_s) begin
                        clear_s     = onehot(Next_priority);
                        grant_nxt_s = onehot(Next_priority);
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                        timer_nxt_s = '0;
                        state_nxt_s = ST_SERVICE;
                    end else begin
                        proto_set_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                // Completion takes precedence over a coincident timeout.
                if (Svc_done) begin
                    grant_nxt_s = '0;
                    state_nxt_s = ST_RECOVER;
                end else if (timer_r == TMO_LAST) begin
                    grant_nxt_s = '0;
                    tout_set_s  = 1'b1;
                    state_nxt_s = ST_RECOVER;
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            ST_RECOVER: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                grant_nxt_s = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pending bits: a new edge wins over a same-cycle grant clear.
    always_comb begin
        pending_nxt_s = (pending_r & ~clear_s) | edge_s;
    end

    // Sticky flags: a flag raised in the same cycle as Err_clr stays set.
    always_comb begin
        if (Err_clr) begin
            ovr_nxt_s   = ovr_set_s;
            tout_nxt_s  = tout_set_s;
            proto_nxt_s = proto_set_s;
        end else begin
            ovr_nxt_s   = ovr_r | ovr_set_s;
            tout_nxt_s  = tout_r | tout_set_s;
            proto_nxt_s = proto_r | proto_set_s;
        end
    end

    // State and datapath registers. Reset clears everything asynchronously,
    // including a grant in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            irq_q_r   <= '0;
            pending_r <= '0;
            grant_r   <= '0;
            ovr_r     <= '0;
            tout_r    <= 1'b0;
            proto_r   <= 1'b0;
            cnt_r     <= '0;
            timer_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            irq_q_r   <= Irq_in;
            pending_r <= pending_nxt_s;
            grant_r   <= grant_nxt_s;
            ovr_r     <= ovr_nxt_s;
            tout_r    <= tout_nxt_s;
            proto_r   <= proto_nxt_s;
            cnt_r     <= cnt_nxt_s;
            timer_r   <= timer_nxt_s;
        end
    end

    // Requests are shown to the arbiter only in IDLE. In RECOVER the bus is
    // all zeros, so the arbiter sees a deassertion between grants.
    always_comb begin
        if (state_r == ST_IDLE) begin
            Priority_bus = pending_r;
        end else begin
            Priority_bus = '0;
        end
    end

    assign Svc_grant   = grant_r;
    assign Overrun     = ovr_r;
    assign Timeout_err = tout_r;
    assign Proto_err   = proto_r;
    assign Grant_cnt   = cnt_r;

endmodule

// File: tb/tb_rr_request_agent.sv
// Self-checking bench for rr_request_agent: directed scenarios plus a
// randomized phase. Each cycle is compared against a transaction-level model.
module tb_rr_request_agent;

    localparam int N           = 4;
    localparam int SVC_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] priority_bus;
    logic [1:0] next_priority;
    logic       data_valid;
    logic [3:0] svc_grant;
    logic       svc_done;
    logic [3:0] overrun;
    logic       timeout_err;
    logic       proto_err;
    logic [7:0] grant_cnt;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [3:0] m_pend;
    logic [3:0] m_prev;
    logic [3:0] m_ovr;
    logic       m_tout;
    logic       m_proto;
    int         m_cnt;
    int         serving;    // index being serviced, -1 when none
    int         svc_age;    // service cycles elapsed for the current grant
    bit         cooldown;   // the single deassertion cycle after a service

    always #5 clk = ~clk;

    rr_request_agent #(.N_SRC(4), .IDX_W(2), .SVC_TIMEOUT(SVC_TIMEOUT), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .Irq_in       (irq_in),
        .Priority_bus (priority_bus),
        .Next_priority(next_priority),
        .Data_Valid   (data_valid),
        .Svc_grant    (svc_grant),
        .Svc_done     (svc_done),
        .Overrun      (overrun),
        .Timeout_err  (timeout_err),
        .Proto_err    (proto_err),
        .Grant_cnt    (grant_cnt),
        .Err_clr      (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] bit_of(input int i);
        logic [3:0] v;
        v = 4'd0;
        for (int k = 0; k < N; k++) begin
            if (k == i) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_pend   = 4'd0;
        m_prev   = 4'd0;
        m_ovr    = 4'd0;
        m_tout   = 1'b0;
        m_proto  = 1'b0;
        m_cnt    = 0;
        serving  = -1;
        svc_age  = 0;
        cooldown = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] rise;
        logic [3:0] set_ovr;
        logic       t_set;
        logic       p_set;
        int         take;
        if (!rst) begin
            model_reset();
        end else begin
            rise    = irq_in & ~m_prev;
            set_ovr = rise & m_pend;
            take    = -1;
            t_set   = 1'b0;
            p_set   = 1'b0;
            if (serving >= 0) begin
                svc_age++;
                if (svc_done) begin
                    serving  = -1;
                    cooldown = 1'b1;
                end else if (svc_age == SVC_TIMEOUT) begin
                    serving  = -1;
                    cooldown = 1'b1;
                    t_set    = 1'b1;
                end
            end else if (cooldown) begin
                cooldown = 1'b0;
            end else if (data_valid) begin
                if (int'(next_priority) < N && m_pend[next_priority]) take = int'(next_priority);
                else p_set = 1'b1;
            end
            if (take >= 0) begin
                m_pend  = m_pend & ~bit_of(take);
                serving = take;
                svc_age = 0;
                m_cnt   = (m_cnt + 1) % 256;
            end
            m_pend = m_pend | rise;
            if (err_clr) begin
                m_ovr   = set_ovr;
                m_tout  = t_set;
                m_proto = p_set;
            end else begin
                m_ovr   = m_ovr | set_ovr;
                m_tout  = m_tout | t_set;
                m_proto = m_proto | p_set;
            end
            m_prev = irq_in;
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_pbus;
        logic [3:0] exp_grant;
        exp_pbus  = (serving < 0 && !cooldown) ? m_pend : 4'd0;
        exp_grant = (serving >= 0) ? bit_of(serving) : 4'd0;
        check_eq("priority_bus", 32'(priority_bus), 32'(exp_pbus));
        check_eq("svc_grant",    32'(svc_grant),    32'(exp_grant));
        check_eq("overrun",      32'(overrun),      32'(m_ovr));
        check_eq("timeout_err",  32'(timeout_err),  32'(m_tout));
        check_eq("proto_err",    32'(proto_err),    32'(m_proto));
        check_eq("grant_cnt",    32'(grant_cnt),    32'(m_cnt));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int cand[$];
        rst = 1'b0; irq_in = 4'hF; next_priority = 2'd0;
        data_valid = 1'b0; svc_done = 1'b0; err_clr = 1'b0;
        model_reset();

        // 1: reset hold with all lines high, then release
        repeat (3) tick();
        check_eq("t1_rst_pbus",  32'(priority_bus), 32'h0);
        check_eq("t1_rst_grant", 32'(svc_grant),    32'h0);
        rst = 1'b1;
        tick();
        check_eq("t1_pbus_all", 32'(priority_bus), 32'hF);

        // 2: grant source 2, done after 3 cycles, one recover cycle
        irq_in = 4'h0; data_valid = 1'b1; next_priority = 2'd2;
        tick();
        check_eq("t2_grant", 32'(svc_grant), 32'h4);
        check_eq("t2_cnt",   32'(grant_cnt), 32'd1);
        data_valid = 1'b0;
        tick(); tick();
        svc_done = 1'b1;
        tick();
        check_eq("t2_grant_drop", 32'(svc_grant),    32'h0);
        check_eq("t2_recover",    32'(priority_bus), 32'h0);
        svc_done = 1'b0;
        tick();
        check_eq("t2_idle_pbus", 32'(priority_bus), 32'hB);

        // 3: grant source 1, no done -> timeout after 15 service cycles
        data_valid = 1'b1; next_priority = 2'd1;
        tick();
        check_eq("t3_grant", 32'(svc_grant), 32'h2);
        data_valid = 1'b0;
        repeat (14) tick();
        check_eq("t3_hold", 32'(svc_grant), 32'h2);
        tick();
        check_eq("t3_timeout_drop", 32'(svc_grant),   32'h0);
        check_eq("t3_timeout_flag", 32'(timeout_err), 32'h1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t3_clr", 32'(timeout_err), 32'h0);

        // 4: overrun on source 0; re-edge of source 3 during its service
        data_valid = 1'b1; next_priority = 2'd0;
        tick();
        data_valid = 1'b0; svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        tick();
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000; tick();
        irq_in = 4'b0001; tick();
        check_eq("t4_overrun0", 32'(overrun), 32'h1);
        irq_in = 4'b0000; data_valid = 1'b1; next_priority = 2'd3;
        tick();
        check_eq("t4_grant3", 32'(svc_grant), 32'h8);
        data_valid = 1'b0; irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000; svc_done = 1'b1;
        tick();
        check_eq("t4_no_ovr3", 32'(overrun), 32'h1);
        svc_done = 1'b0;
        tick();
        check_eq("t4_pend3", 32'(priority_bus), 32'h9);

        // 5: protocol error on non-pending index
        data_valid = 1'b1; next_priority = 2'd3;
        tick();
        data_valid = 1'b0; svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        tick();
        check_eq("t5_pend", 32'(priority_bus), 32'h1);
        data_valid = 1'b1; next_priority = 2'd3;
        tick();
        check_eq("t5_proto",   32'(proto_err), 32'h1);
        check_eq("t5_nogrant", 32'(svc_grant), 32'h0);
        check_eq("t5_cnt",     32'(grant_cnt), 32'd5);
        data_valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // randomized traffic with an arbiter that mostly names pending sources
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) irq_in[b] = ~irq_in[b];
            end
            data_valid = ($urandom_range(1) == 1);
            cand.delete();
            for (int b = 0; b < N; b++) begin
                if (m_pend[b]) cand.push_back(b);
            end
            if (cand.size() > 0 && $urandom_range(3) != 0)
                next_priority = 2'(cand[$urandom_range(cand.size() - 1)]);
            else
                next_priority = 2'($urandom_range(3));
            svc_done = ($urandom_range(5) == 0);
            err_clr  = ($urandom_range(31) == 0);
            tick();
        end

        // 6: 256 grants wrap the counter; async reset mid-service
        rst = 1'b0; irq_in = 4'h0; data_valid = 1'b0; svc_done = 1'b0; err_clr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int g = 0; g < 256; g++) begin
            irq_in = 4'b0001; tick();
            irq_in = 4'b0000; data_valid = 1'b1; next_priority = 2'd0; tick();
            data_valid = 1'b0; svc_done = 1'b1; tick();
            svc_done = 1'b0; tick();
        end
        check_eq("t6_wrap", 32'(grant_cnt), 32'd0);
        irq_in = 4'b0010; tick();
        irq_in = 4'b0000; data_valid = 1'b1; next_priority = 2'd1; tick();
        data_valid = 1'b0;
        check_eq("t6_grant", 32'(svc_grant), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_async_grant", 32'(svc_grant), 32'h0);
        check_eq("t6_async_cnt",   32'(grant_cnt), 32'h0);
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("t6_idle_pbus", 32'(priority_bus), 32'h0);
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; data_valid = 1'b1; next_priority = 2'd2; tick();
        data_valid = 1'b0;
        check_eq("t6_idle_grant", 32'(svc_grant), 32'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
